regfile_multiport: RTL and testbench
====================================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter XLEN, default 64: register data width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers, power of two, 2..64.
REQ-003 Parameter AW, default 6: register index width; must satisfy 2**AW >= NREG.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rs1  in  AW  read port 1 index.
REQ-007 rs2  in  AW  read port 2 index.
REQ-008 rd  in  AW  write index.
REQ-009 wrt_data  in  XLEN  write data, signed.
REQ-010 RegWrite  in  1  write enable.
REQ-011 busy_set  in  1  marks register busy_idx pending, for the scoreboard.
REQ-012 busy_idx  in  AW  register index to mark pending.
REQ-013 read_data_1  out  XLEN  data for rs1.
REQ-014 read_data_2  out  XLEN  data for rs2.
REQ-015 rs1_busy  out  1  register rs1 has a pending write.
REQ-016 rs2_busy  out  1  register rs2 has a pending write.
REQ-017 ready  out  1  clear sweep complete; block accepts writes.

Function
REQ-018 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-019 CLEAR behaviour: a counter walks 0..NREG-1, zeroing one register per cycle.
REQ-020 CLEAR exit: the FSM moves to RUN on the cycle after the counter reaches NREG-1, so ready rises exactly NREG cycles after rst deasserts.
REQ-021 RegWrite and busy_set SHALL be ignored during CLEAR.
REQ-022 Reads during CLEAR SHALL return 0; busy outputs SHALL be 0.
REQ-023 In RUN, RegWrite=1 with rd!=0 SHALL write wrt_data to register rd at the rising edge.
REQ-024 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-025 Reads SHALL be combinational from rs1/rs2, with zero-cycle latency.
REQ-026 Index bound: rs1, rs2, rd or busy_idx >= NREG SHALL read 0 and write nothing.
REQ-027 Scoreboard: each register has a busy bit; busy_set in RUN with busy_idx!=0 sets the bit at the edge.
REQ-028 A RegWrite to rd SHALL clear busy bit rd at the same edge.
REQ-029 If busy_set and RegWrite target the same index in the same cycle, the busy bit SHALL end set, because set wins.
REQ-030 Busy bit 0 SHALL always read 0.
REQ-031 rs1_busy/rs2_busy SHALL reflect the registered busy bits, and are not bypassed.
REQ-032 Both read ports SHALL be independent; rs1==rs2 returns identical data on both.

Reset
REQ-033 rst=1 at a rising edge SHALL force the FSM to CLEAR, zero the counter, clear all busy bits and drive ready=0.
REQ-034 Outputs under reset: read_data_1=read_data_2=0 and rs1_busy=rs2_busy=0 while rst is high and throughout CLEAR.
REQ-035 rst asserted mid-sweep or mid-RUN SHALL restart the sweep from index 0.
REQ-036 Register contents are not guaranteed until ready=1.

Configuration
REQ-037 Macro REGFILE_BYPASS_EN controls write-to-read forwarding.
REQ-038 With REGFILE_BYPASS_EN defined: in RUN, if RegWrite=1 and rd!=0 and rsN==rd, read_data_N SHALL equal wrt_data in that same cycle.
REQ-039 Without REGFILE_BYPASS_EN: reads SHALL return the pre-edge stored value, and the new value appears the cycle after the write.

Verification
REQ-040 Sweep: rst high 2 cycles, then low -> ready=0 for exactly 32 cycles, ready=1 at cycle 32, and every register reads 0.
REQ-041 Write/read and x0 protection: write rd=5 data 0x1234, then rd=0 data 0xFFFF -> rs1=5 reads 0x1234 and rs2=0 reads 0.
REQ-042 Forwarding: RegWrite rd=7 data -3 with rs1=7 in the same cycle -> read_data_1=-3 that cycle if REGFILE_BYPASS_EN, else the old value, then -3 the next cycle.
REQ-043 Scoreboard: busy_set idx=9, then rs2=9 -> rs2_busy=1; write rd=9 -> rs2_busy=0 next cycle; busy_set and RegWrite both idx=9 together -> busy stays 1.
REQ-044 Mid-sweep reset: rst pulsed at sweep cycle 10 -> ready stays 0 for a further full 32 cycles; RegWrite during the sweep has no effect.
REQ-045 Parametric: NREG=8, XLEN=32 -> ready after 8 cycles; rs1=9 reads 0.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multiported register file (2R/1W) with power-up clear sweep and per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_multiport #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          rs1,
    input  logic [AW-1:0]          rs2,
    input  logic [AW-1:0]          rd,
    input  logic signed [XLEN-1:0] wrt_data,
    input  logic                   RegWrite,
    input  logic                   busy_set,
    input  logic [AW-1:0]          busy_idx,
    output logic [XLEN-1:0]        read_data_1,
    output logic [XLEN-1:0]        read_data_2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   ready
);

    localparam int NPORT = 2;
    localparam int IW    = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      cnt, cnt_nxt;
    logic [XLEN-1:0]    regs [NREG];
    logic [NREG-1:0]    busy;

    logic               run;
    logic               wr_ok;
    logic               set_ok;
    logic [IW-1:0]      rd_i;
    logic [IW-1:0]      set_i;

    logic [NPORT-1:0][AW-1:0]   rs;
    logic [NPORT-1:0][XLEN-1:0] rdata;
    logic [NPORT-1:0]           rbusy;

    // Indices are range-checked at full AW width before being narrowed to IW.
    function automatic logic in_range(input logic [AW-1:0] idx);
        return {1'b0, idx} < (AW+1)'(NREG);
    endfunction

    // Everything is gated with rst so outputs are quiet for the whole reset pulse.
    assign run    = (state == RUN) && !rst;
    assign ready  = run;
    assign rd_i   = rd[IW-1:0];
    assign set_i  = busy_idx[IW-1:0];
    assign wr_ok  = run && RegWrite && (rd != '0) && in_range(rd);
    assign set_ok = run && busy_set && (busy_idx != '0) && in_range(busy_idx);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                if (cnt == IW'(NREG-1)) state_nxt = RUN;
                else                    cnt_nxt   = cnt + 1'b1;
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Storage has no reset of its own; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                regs[cnt] <= '0;
            else if (wr_ok)
                regs[rd_i] <= wrt_data;
        end
    end

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_ok)  busy[rd_i]  <= 1'b0;
            if (set_ok) busy[set_i] <= 1'b1;
        end
    end

    assign rs = {rs2, rs1};

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic          ok;
        logic          fwd;
        logic [IW-1:0] idx;

        assign idx = rs[p][IW-1:0];
        assign ok  = run && (rs[p] != '0) && in_range(rs[p]);
`ifdef REGFILE_BYPASS_EN
        assign fwd = wr_ok && (rs[p] == rd);
`else
        assign fwd = 1'b0;
`endif
        always_comb begin
            rdata[p] = '0;
            if (ok) rdata[p] = fwd ? wrt_data : regs[idx];
        end

        assign rbusy[p] = ok && busy[idx];
    end

    assign read_data_1 = rdata[0];
    assign read_data_2 = rdata[1];
    assign rs1_busy    = rbusy[0];
    assign rs2_busy    = rbusy[1];

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: sweep, writes, x0, forwarding, scoreboard, resets, small config.
module tb_regfile_multiport;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, RegWrite, busy_set;
    logic [AW-1:0]          rs1, rs2, rd, busy_idx;
    logic signed [XLEN-1:0] wrt_data;
    logic [XLEN-1:0]        read_data_1, read_data_2;
    logic                   rs1_busy, rs2_busy, ready;

    logic                   rst8, RegWrite8, busy_set8;
    logic [3:0]             rs1_8, rs2_8, rd8, busy_idx8;
    logic signed [31:0]     wrt_data8;
    logic [31:0]            read_data_1_8, read_data_2_8;
    logic                   rs1_busy8, rs2_busy8, ready8;

    int total = 0;
    int bad   = 0;

    regfile_multiport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .wrt_data(wrt_data),
        .RegWrite(RegWrite), .busy_set(busy_set), .busy_idx(busy_idx),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .ready(ready)
    );

    regfile_multiport #(.XLEN(32), .NREG(8), .AW(4)) dut8 (
        .clk(clk), .rst(rst8), .rs1(rs1_8), .rs2(rs2_8), .rd(rd8), .wrt_data(wrt_data8),
        .RegWrite(RegWrite8), .busy_set(busy_set8), .busy_idx(busy_idx8),
        .read_data_1(read_data_1_8), .read_data_2(read_data_2_8),
        .rs1_busy(rs1_busy8), .rs2_busy(rs2_busy8), .ready(ready8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (read_data_1 !== '0) begin bad++; $display("FAIL reset_rd1: got %h want 0", read_data_1); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", rs1_busy); end
        // Write and busy attempts are held on throughout the sweep and must be ignored.
        rst = 1'b0; RegWrite = 1'b1; rd = 6'd3; wrt_data = 64'sd77;
        busy_set = 1'b1; busy_idx = 6'd3; rs1 = 6'd3; rs2 = 6'd3;
        for (int k = 1; k <= NREG; k++) begin
            step();
            if (k == NREG - 1) begin RegWrite = 1'b0; busy_set = 1'b0; end
            total++;
            if (ready !== (k == NREG)) begin
                bad++; $display("FAIL sweep_ready cycle %0d: got %b want %b", k, ready, (k == NREG));
            end
            if (k < NREG) begin
                total++;
                if (read_data_1 !== '0 || rs2_busy !== 1'b0) begin
                    bad++; $display("FAIL sweep_quiet cycle %0d: got %h/%b want 0/0", k, read_data_1, rs2_busy);
                end
            end
        end
        for (int i = 0; i < NREG; i++) begin
            rs1 = AW'(i); rs2 = AW'(NREG - 1 - i);
            #1;
            total++;
            if (read_data_1 !== '0 || read_data_2 !== '0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                bad++; $display("FAIL cleared_reg %0d: got %h %h %b %b want zeros", i, read_data_1, read_data_2, rs1_busy, rs2_busy);
            end
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; rd = 6'd5; wrt_data = 64'sh1234;
        step();
        rd = 6'd0; wrt_data = 64'shFFFF;
        step();
        RegWrite = 1'b0; rs1 = 6'd5; rs2 = 6'd0;
        #1;
        total++; if (read_data_1 !== 64'h1234) begin bad++; $display("FAIL write_r5: got %h want 1234", read_data_1); end
        total++; if (read_data_2 !== 64'h0) begin bad++; $display("FAIL x0_read: got %h want 0", read_data_2); end
        RegWrite = 1'b1; rd = 6'd31; wrt_data = -64'sd1;
        step();
        RegWrite = 1'b0; rs1 = 6'd31; rs2 = 6'd31;
        #1;
        total++;
        if (read_data_1 !== {XLEN{1'b1}} || read_data_2 !== {XLEN{1'b1}}) begin
            bad++; $display("FAIL top_reg: got %h %h want all ones", read_data_1, read_data_2);
        end
        // rd=40 narrows to 8 if the bound check is lost.
        RegWrite = 1'b1; rd = 6'd40; wrt_data = 64'shDEAD;
        step();
        RegWrite = 1'b0; rs1 = 6'd40; rs2 = 6'd8;
        #1;
        total++; if (read_data_1 !== 64'h0) begin bad++; $display("FAIL oob_read: got %h want 0", read_data_1); end
        total++; if (read_data_2 !== 64'h0) begin bad++; $display("FAIL oob_alias: got %h want 0", read_data_2); end
    endtask

    task automatic test_forward();
        logic [XLEN-1:0] exp_now;
        RegWrite = 1'b1; rd = 6'd7; wrt_data = 64'sd100;
        step();
        wrt_data = -64'sd3; rs1 = 6'd7; rs2 = 6'd6;
`ifdef REGFILE_BYPASS_EN
        exp_now = 64'hFFFF_FFFF_FFFF_FFFD;
`else
        exp_now = 64'd100;
`endif
        #1;
        total++; if (read_data_1 !== exp_now) begin bad++; $display("FAIL fwd_same_cycle: got %h want %h", read_data_1, exp_now); end
        total++; if (read_data_2 !== 64'h0) begin bad++; $display("FAIL fwd_other_port: got %h want 0", read_data_2); end
        step();
        RegWrite = 1'b0; rs2 = 6'd7;
        #1;
        total++;
        if (read_data_1 !== 64'hFFFF_FFFF_FFFF_FFFD || read_data_2 !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            bad++; $display("FAIL fwd_next_cycle: got %h %h want fffffffffffffffd", read_data_1, read_data_2);
        end
    endtask

    task automatic test_scoreboard();
        busy_set = 1'b1; busy_idx = 6'd9; rs1 = 6'd9; rs2 = 6'd9;
        #1;
        total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL busy_no_bypass: got %b want 0", rs2_busy); end
        step();
        busy_set = 1'b0;
        #1;
        total++; if (rs2_busy !== 1'b1 || rs1_busy !== 1'b1) begin bad++; $display("FAIL busy_set: got %b %b want 1 1", rs1_busy, rs2_busy); end
        RegWrite = 1'b1; rd = 6'd9; wrt_data = 64'sd5;
        step();
        RegWrite = 1'b0;
        #1;
        total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL busy_clear: got %b want 0", rs2_busy); end
        RegWrite = 1'b1; rd = 6'd9; wrt_data = 64'sd6; busy_set = 1'b1; busy_idx = 6'd9;
        step();
        RegWrite = 1'b0; busy_set = 1'b0;
        #1;
        total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL busy_set_wins: got %b want 1", rs2_busy); end
        total++; if (read_data_2 !== 64'd6) begin bad++; $display("FAIL busy_collide_data: got %h want 6", read_data_2); end
        busy_set = 1'b1; busy_idx = 6'd0;
        step();
        busy_idx = 6'd40;
        step();
        busy_set = 1'b0; rs1 = 6'd0; rs2 = 6'd8;
        #1;
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL busy_x0: got %b want 0", rs1_busy); end
        total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL busy_oob: got %b want 0", rs2_busy); end
    endtask

    task automatic test_mid_reset();
        rs1 = 6'd5; rs2 = 6'd9;
        rst = 1'b1;
        #1;
        total++;
        if (read_data_1 !== '0 || rs2_busy !== 1'b0 || ready !== 1'b0) begin
            bad++; $display("FAIL run_reset_outputs: got %h %b %b want 0 0 0", read_data_1, rs2_busy, ready);
        end
        step();
        rst = 1'b0; RegWrite = 1'b1; rd = 6'd4; wrt_data = 64'shAA;
        for (int k = 1; k <= 10; k++) begin
            step();
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL pre_pulse_ready cycle %0d: got %b want 0", k, ready); end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= NREG; k++) begin
            step();
            if (k == NREG - 1) RegWrite = 1'b0;
            total++;
            if (ready !== (k == NREG)) begin
                bad++; $display("FAIL resweep_ready cycle %0d: got %b want %b", k, ready, (k == NREG));
            end
        end
        rs1 = 6'd4;
        #1;
        total++; if (read_data_1 !== 64'h0) begin bad++; $display("FAIL sweep_write_ignored: got %h want 0", read_data_1); end
        total++; if (read_data_2 !== 64'h0 || rs2_busy !== 1'b0) begin bad++; $display("FAIL resweep_cleared: got %h %b want 0 0", read_data_2, rs2_busy); end
        rs1 = 6'd5;
        #1;
        total++; if (read_data_1 !== 64'h0) begin bad++; $display("FAIL resweep_r5: got %h want 0", read_data_1); end
    endtask

    task automatic test_param();
        rst8 = 1'b1;
        step();
        step();
        rst8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (ready8 !== (k == 8)) begin bad++; $display("FAIL p8_ready cycle %0d: got %b want %b", k, ready8, (k == 8)); end
        end
        RegWrite8 = 1'b1; rd8 = 4'd1; wrt_data8 = 32'sh11;
        step();
        rd8 = 4'd9; wrt_data8 = 32'sh55;
        step();
        rd8 = 4'd7; wrt_data8 = 32'sh77;
        step();
        RegWrite8 = 1'b0; rs1_8 = 4'd9; rs2_8 = 4'd1;
        #1;
        total++; if (read_data_1_8 !== 32'h0) begin bad++; $display("FAIL p8_oob_read: got %h want 0", read_data_1_8); end
        total++; if (read_data_2_8 !== 32'h11) begin bad++; $display("FAIL p8_no_alias: got %h want 11", read_data_2_8); end
        rs1_8 = 4'd7;
        #1;
        total++; if (read_data_1_8 !== 32'h77) begin bad++; $display("FAIL p8_top_reg: got %h want 77", read_data_1_8); end
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; busy_set = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; busy_idx = '0; wrt_data = '0;
        rst8 = 1'b1; RegWrite8 = 1'b0; busy_set8 = 1'b0;
        rs1_8 = '0; rs2_8 = '0; rd8 = '0; busy_idx8 = '0; wrt_data8 = '0;
        test_reset();
        test_write_read();
        test_forward();
        test_scoreboard();
        test_mid_reset();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
